// File: rtl/loopback_pkg.sv
// rtl/loopback_pkg.sv - shared types and constants for the RX loopback pattern checker
package loopback_pkg;

  localparam int BYTE_W = 8;
  localparam logic [BYTE_W-1:0] PATTERN_STEP = 8'd1;

  typedef enum logic {
    ST_HUNT   = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

endpackage

// File: rtl/bit_aligner.sv
// rtl/bit_aligner.sv - rotates the raw RX byte stream by a selectable bit offset
module bit_aligner
  import loopback_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [BYTE_W-1:0] data_in,
  input  logic              data_valid,
  input  logic [2:0]        bit_offset,
  input  logic              offset_chg,
  output logic [BYTE_W-1:0] aligned_data,
  output logic              aligned_valid
);

  logic [BYTE_W-1:0]   prev;
  logic [2*BYTE_W-1:0] window;

  assign window = {data_in, prev};

  // A byte captured while the offset is being changed would use the stale rotation, so it is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev          <= '0;
      aligned_data  <= '0;
      aligned_valid <= 1'b0;
    end else begin
      aligned_valid <= data_valid && !offset_chg;
      if (data_valid) begin
        prev <= data_in;
        if (!offset_chg) begin
          aligned_data <= window[bit_offset +: BYTE_W];
        end
      end
    end
  end

endmodule

// File: rtl/loopback_checker.sv
// rtl/loopback_checker.sv - hunts for bit alignment and lock on the incrementing TX counter pattern
module loopback_checker
  import loopback_pkg::*;
#(
  parameter int LOCK_CNT = 16,
  parameter int LOSS_CNT = 4,
  parameter int HUNT_WIN = 32,
  parameter int ERR_W    = 32,
  parameter int CNT_W    = 48
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [BYTE_W-1:0] data_in,
  input  logic              data_valid,
  input  logic              clear_cnt,
  output logic [BYTE_W-1:0] aligned_data,
  output logic              aligned_valid,
  output logic [2:0]        bit_offset,
  output logic              locked,
  output logic              err_flag,
  output logic [ERR_W-1:0]  err_cnt,
  output logic [CNT_W-1:0]  word_cnt
);

  localparam int RUN_W  = $clog2(LOCK_CNT + 1);
  localparam int MISS_W = $clog2(LOSS_CNT + 1);
  localparam int HUNT_W = $clog2(HUNT_WIN + 1);

  state_t              state, state_d;
  logic [RUN_W-1:0]    run, run_d;
  logic [MISS_W-1:0]   miss, miss_d, miss_nxt;
  logic [HUNT_W-1:0]   hunt, hunt_d, hunt_nxt;
  logic                seed, seed_d;
  logic [BYTE_W-1:0]   last, last_d;
  logic [2:0]          offset_d;
  logic [ERR_W-1:0]    err_d;
  logic [CNT_W-1:0]    word_d;
  logic                flag_d;
  logic                offset_chg;
  logic                match;

  bit_aligner u_aligner (
    .clk          (clk),
    .rst_n        (rst_n),
    .data_in      (data_in),
    .data_valid   (data_valid),
    .bit_offset   (bit_offset),
    .offset_chg   (offset_chg),
    .aligned_data (aligned_data),
    .aligned_valid(aligned_valid)
  );

  assign locked = (state == ST_LOCKED);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_HUNT;
      run        <= '0;
      miss       <= '0;
      hunt       <= '0;
      seed       <= 1'b1;
      last       <= '0;
      bit_offset <= '0;
      err_cnt    <= '0;
      word_cnt   <= '0;
      err_flag   <= 1'b0;
    end else begin
      state      <= state_d;
      run        <= run_d;
      miss       <= miss_d;
      hunt       <= hunt_d;
      seed       <= seed_d;
      last       <= last_d;
      bit_offset <= offset_d;
      err_cnt    <= err_d;
      word_cnt   <= word_d;
      err_flag   <= flag_d;
    end
  end

  always_comb begin
    state_d    = state;
    run_d      = run;
    miss_d     = miss;
    hunt_d     = hunt;
    seed_d     = seed;
    last_d     = last;
    offset_d   = bit_offset;
    err_d      = err_cnt;
    word_d     = word_cnt;
    flag_d     = 1'b0;
    offset_chg = 1'b0;
    match      = (aligned_data == last + PATTERN_STEP);
    hunt_nxt   = hunt + 1'b1;
    miss_nxt   = miss + 1'b1;

    if (aligned_valid) begin
      last_d = aligned_data;
      seed_d = 1'b0;
      case (state)
        ST_HUNT: begin
          hunt_d = hunt_nxt;
          if (!seed) begin
            run_d = match ? run + 1'b1 : '0;
          end
          if (!seed && match && run == RUN_W'(LOCK_CNT - 2)) begin
            state_d = ST_LOCKED;
            run_d   = '0;
            hunt_d  = '0;
          end else if (hunt_nxt == HUNT_W'(HUNT_WIN)) begin
            offset_d   = bit_offset + 3'd1;
            offset_chg = 1'b1;
            run_d      = '0;
            hunt_d     = '0;
            seed_d     = 1'b1;
          end
        end
        ST_LOCKED: begin
          word_d = (&word_cnt) ? word_cnt : word_cnt + 1'b1;
          if (match) begin
            miss_d = '0;
          end else begin
            err_d  = (&err_cnt) ? err_cnt : err_cnt + 1'b1;
            flag_d = 1'b1;
            miss_d = miss_nxt;
            if (miss_nxt == MISS_W'(LOSS_CNT)) begin
              state_d = ST_HUNT;
              miss_d  = '0;
              seed_d  = 1'b1;
            end
          end
        end
      endcase
    end

    // Clear takes priority over a same-cycle increment; the error pulse is still reported.
    if (clear_cnt) begin
      err_d  = '0;
      word_d = '0;
    end
  end

endmodule
